vga_frame_scan: RTL and testbench

- Parametrised successor to the 640x480 VGA scan/readout block of the dual-camera design.
- Generates configurable VGA timing and a frame-buffer read address for an image window centred in the active area.
- Compensates BRAM read latency and shows one of two camera channels, or both side-by-side.
- Supports colour or thresholded binary output; the threshold is adjusted by saturating button steps.

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_frame_scan_thresh_adj.sv | 70 +++++++
 rtl/vga_frame_scan.sv | 203 ++++++++++++++++++++
 tb/tb_vga_frame_scan.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA frame scanner:
//   - default 640x480@60 timing (sync, porches, active area)
//   - luma weights used by the binary (thresholded) output path
//   - bit positions of the R/G/B fields inside a 12-bit camera pixel
//   - the per-clock tap record carried through the read-latency delay line
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_H_ACT  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int VGA_V_ACT  = 480;
    localparam int VGA_V_FP   = 10;

    // Weights sum to 100, so a full-scale pixel gives luma 1500 (fits 11 bits).
    localparam int LUMA_WR = 30;
    localparam int LUMA_WG = 59;
    localparam int LUMA_WB = 11;

    localparam int PIX_R_MSB = 11;
    localparam int PIX_R_LSB = 8;
    localparam int PIX_G_MSB = 7;
    localparam int PIX_G_LSB = 4;
    localparam int PIX_B_MSB = 3;
    localparam int PIX_B_LSB = 0;

    // Everything that must travel alongside a read address until its data returns.
    typedef struct packed {
        logic hs;   // raw hsync level (active low)
        logic vs;   // raw vsync level (active low)
        logic win;  // address belongs to the image window
        logic sel;  // 0: camera 0, 1: camera 1
    } scan_tap_t;

    localparam scan_tap_t TAP_IDLE = '{hs: 1'b1, vs: 1'b1, win: 1'b0, sel: 1'b0};

    function automatic logic [10:0] luma_of(input logic [11:0] pix);
        return 11'(pix[PIX_R_MSB:PIX_R_LSB]) * 11'(LUMA_WR)
             + 11'(pix[PIX_G_MSB:PIX_G_LSB]) * 11'(LUMA_WG)
             + 11'(pix[PIX_B_MSB:PIX_B_LSB]) * 11'(LUMA_WB);
    endfunction

endpackage

// File: rtl/vga_frame_scan_thresh_adj.sv
// -----------------------------------------------------------------------------
// thresh_adj
// Binary-output threshold register driven by two raw (already debounced)
// buttons. Each button is brought into the clock domain with a 2-FF
// synchroniser and reduced to a rising-edge pulse, so a held button yields
// exactly one step. Steps saturate: a step that would leave [TH_MIN, TH_MAX]
// is dropped entirely. Simultaneous up and down edges cancel.
// Ports:
//   clk_i        pixel clock
//   rst_ni       asynchronous active-low reset
//   up_i         raw button, raise threshold
//   down_i       raw button, lower threshold
//   threshold_o  current threshold
// -----------------------------------------------------------------------------
module thresh_adj #(
    parameter int TH_INIT = 650,
    parameter int TH_STEP = 20,
    parameter int TH_MIN  = 200,
    parameter int TH_MAX  = 1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        up_i,
    input  logic        down_i,
    output logic [15:0] threshold_o
);

    // [0],[1]: synchroniser; [2]: previous synchronised level for edge detect.
    logic [2:0]  up_pipe_q;
    logic [2:0]  dn_pipe_q;
    logic        up_edge;
    logic        dn_edge;
    logic [15:0] th_q;
    logic [15:0] th_d;
    logic [16:0] th_up_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            up_pipe_q <= '0;
            dn_pipe_q <= '0;
            th_q      <= 16'(TH_INIT);
        end else begin
            up_pipe_q <= {up_pipe_q[1:0], up_i};
            dn_pipe_q <= {dn_pipe_q[1:0], down_i};
            th_q      <= th_d;
        end
    end

    assign up_edge = up_pipe_q[1] & ~up_pipe_q[2];
    assign dn_edge = dn_pipe_q[1] & ~dn_pipe_q[2];

    always_comb begin
        th_d      = th_q;
        // One extra bit so the upper-bound test cannot wrap.
        th_up_sum = {1'b0, th_q} + 17'(TH_STEP);
        if (up_edge && !dn_edge) begin
            if (th_up_sum <= 17'(TH_MAX)) begin
                th_d = th_up_sum[15:0];
            end
        end else if (dn_edge && !up_edge) begin
            // Compare before subtracting so the result can never underflow.
            if (th_q >= 16'(TH_MIN + TH_STEP)) begin
                th_d = th_q - 16'(TH_STEP);
            end
        end
    end

    assign threshold_o = th_q;

endmodule

// File: rtl/vga_frame_scan.sv
// -----------------------------------------------------------------------------
// vga_frame_scan
// VGA timing generator and frame-buffer readout. An IMG_W x IMG_H window is
// centred in the active area; inside it rd_addr walks 0..IMG_W*IMG_H-1 once
// per frame. Sync, window and channel select travel through an RD_LAT-deep
// delay line so they meet the BRAM data, and the output register adds the
// final clock: a pixel reaches red/green/blue RD_LAT+1 clocks after its
// address, in step with hs/vs.
// Ports:
//   clk_25m, rst_n         pixel clock, asynchronous active-low reset
//   ch0_data, ch1_data     camera pixels {R,G,B}, valid RD_LAT clocks after rd_addr
//   split_en, ch_sel       side-by-side mode / channel for single-channel mode
//   bin_mode               1: thresholded luma output, 0: colour
//   adj_up, adj_down       raw threshold buttons
//   rd_addr                shared frame-buffer read address
//   red, green, blue       pixel output (0 outside the window)
//   hs, vs                 syncs, active low
//   threshold              current binary threshold
//   frame_start            one-clock pulse while the counters sit at h=0, v=0
// -----------------------------------------------------------------------------
module vga_frame_scan
    import vga_pkg::*;
#(
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int H_ACT   = VGA_H_ACT,
    parameter int H_FP    = VGA_H_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP,
    parameter int V_ACT   = VGA_V_ACT,
    parameter int V_FP    = VGA_V_FP,
    parameter int IMG_W   = VGA_H_ACT,
    parameter int IMG_H   = VGA_V_ACT,
    parameter int ADDR_W  = 20,
    parameter int RD_LAT  = 1,
    parameter int TH_INIT = 650,
    parameter int TH_STEP = 20,
    parameter int TH_MIN  = 200,
    parameter int TH_MAX  = 1000
) (
    input  logic              clk_25m,
    input  logic              rst_n,
    input  logic [11:0]       ch0_data,
    input  logic [11:0]       ch1_data,
    input  logic              split_en,
    input  logic              ch_sel,
    input  logic              bin_mode,
    input  logic              adj_up,
    input  logic              adj_down,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hs,
    output logic              vs,
    output logic [15:0]       threshold,
    output logic              frame_start
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HC_W  = $clog2(H_TOT);
    localparam int VC_W  = $clog2(V_TOT);

    localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOT - 1);
    localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOT - 1);
    localparam logic [HC_W-1:0] H_SYN_E = HC_W'(H_SYNC);
    localparam logic [VC_W-1:0] V_SYN_E = VC_W'(V_SYNC);
    localparam logic [HC_W-1:0] H_WIN_S = HC_W'(H_SYNC + H_BP + (H_ACT - IMG_W) / 2);
    localparam logic [HC_W-1:0] H_WIN_E = HC_W'(H_SYNC + H_BP + (H_ACT - IMG_W) / 2 + IMG_W);
    localparam logic [HC_W-1:0] H_SPLIT = HC_W'(H_SYNC + H_BP + (H_ACT - IMG_W) / 2 + IMG_W / 2);
    localparam logic [VC_W-1:0] V_WIN_S = VC_W'(V_SYNC + V_BP + (V_ACT - IMG_H) / 2);
    localparam logic [VC_W-1:0] V_WIN_E = VC_W'(V_SYNC + V_BP + (V_ACT - IMG_H) / 2 + IMG_H);

    logic [HC_W-1:0]   h_cnt_q, h_cnt_d;
    logic [VC_W-1:0]   v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              frame_start_q, frame_start_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              hs_q, vs_q;
    logic              win;
    logic              at_origin;
    logic [11:0]       pix_sel;
    logic [15:0]       th_val;
    scan_tap_t         tap_in;
    scan_tap_t         tap_out;

    always_comb begin
        h_cnt_d = h_cnt_q + HC_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VC_W'(1);
        end
    end

    assign win = (h_cnt_q >= H_WIN_S) && (h_cnt_q < H_WIN_E)
              && (v_cnt_q >= V_WIN_S) && (v_cnt_q < V_WIN_E);
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Reloading at the frame origin resynchronises the address every frame,
    // so a disturbed count can never drift across frames.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (at_origin) begin
            rd_addr_d = '0;
        end else if (win) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
    end

    // Registered from the next-state counters so the pulse lines up with h=0, v=0.
    assign frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rd_addr_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rd_addr_q     <= rd_addr_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Channel select is sampled together with the address it belongs to.
    assign tap_in = '{hs:  (h_cnt_q >= H_SYN_E),
                      vs:  (v_cnt_q >= V_SYN_E),
                      win: win,
                      sel: split_en ? (h_cnt_q >= H_SPLIT) : ch_sel};

    // RD_LAT stages here plus the output register give the RD_LAT+1 alignment.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_tap
            scan_tap_t tap_q;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk_25m or negedge rst_n) begin
                    if (!rst_n) tap_q <= TAP_IDLE;
                    else        tap_q <= tap_in;
                end
            end else begin : g_body
                always_ff @(posedge clk_25m or negedge rst_n) begin
                    if (!rst_n) tap_q <= TAP_IDLE;
                    else        tap_q <= g_tap[gi-1].tap_q;
                end
            end
        end
    endgenerate

    assign tap_out = g_tap[RD_LAT-1].tap_q;

    always_comb begin
        pix_sel = tap_out.sel ? ch1_data : ch0_data;
        rgb_d   = '0;
        if (tap_out.win) begin
            if (bin_mode) begin
                // Strictly greater: luma equal to the threshold renders black.
                rgb_d = ({5'd0, luma_of(pix_sel)} > th_val) ? 12'hFFF : 12'h000;
            end else begin
                rgb_d = pix_sel;
            end
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= tap_out.hs;
            vs_q  <= tap_out.vs;
        end
    end

    thresh_adj #(
        .TH_INIT (TH_INIT),
        .TH_STEP (TH_STEP),
        .TH_MIN  (TH_MIN),
        .TH_MAX  (TH_MAX)
    ) u_thresh_adj (
        .clk_i       (clk_25m),
        .rst_ni      (rst_n),
        .up_i        (adj_up),
        .down_i      (adj_down),
        .threshold_o (th_val)
    );

    assign rd_addr     = rd_addr_q;
    assign red         = rgb_q[PIX_R_MSB:PIX_R_LSB];
    assign green       = rgb_q[PIX_G_MSB:PIX_G_LSB];
    assign blue        = rgb_q[PIX_B_MSB:PIX_B_LSB];
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign threshold   = th_val;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_scan.sv
// -----------------------------------------------------------------------------
// Bench for vga_frame_scan on a shrunken raster (25 x 15 clocks, 12 x 8 window,
// RD_LAT=2). A BRAM model answers rd_addr; a reference model derives every
// output from the absolute clock index since reset release.
// -----------------------------------------------------------------------------
module tb_vga_frame_scan;

    localparam int H_SYNC = 4,  H_BP = 3, H_ACT = 16, H_FP = 2;
    localparam int V_SYNC = 2,  V_BP = 2, V_ACT = 10, V_FP = 1;
    localparam int IMG_W  = 12, IMG_H = 8;
    localparam int LAT    = 2;
    localparam int H_TOT  = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT  = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam int H0     = H_SYNC + H_BP + (H_ACT - IMG_W) / 2;
    localparam int V0     = V_SYNC + V_BP + (V_ACT - IMG_H) / 2;
    localparam int NPIX   = IMG_W * IMG_H;

    logic        clk_25m = 1'b0;
    logic        rst_n;
    logic [11:0] ch0_data, ch1_data;
    logic        split_en, ch_sel, bin_mode, adj_up, adj_down;
    logic [19:0] rd_addr;
    logic [3:0]  red, green, blue;
    logic        hs, vs, frame_start;
    logic [15:0] threshold;

    vga_frame_scan #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(20), .RD_LAT(LAT),
        .TH_INIT(650), .TH_STEP(20), .TH_MIN(200), .TH_MAX(1000)
    ) dut (
        .clk_25m(clk_25m), .rst_n(rst_n),
        .ch0_data(ch0_data), .ch1_data(ch1_data),
        .split_en(split_en), .ch_sel(ch_sel), .bin_mode(bin_mode),
        .adj_up(adj_up), .adj_down(adj_down),
        .rd_addr(rd_addr), .red(red), .green(green), .blue(blue),
        .hs(hs), .vs(vs), .threshold(threshold), .frame_start(frame_start)
    );

    always #5 clk_25m = ~clk_25m;

    int total = 0;
    int bad   = 0;
    int n     = 0;        // clocks since reset release
    int th_m  = 650;      // threshold model
    int last_win_addr;
    logic [11:0] cap_l, cap_r;
    bit  rand_on = 0;
    bit  split_req = 0, sel_req = 0, bin_req = 0;

    logic [11:0] mem0 [128];
    logic [11:0] mem1 [128];
    int  addr_hist [8192];
    bit  split_h   [8192];
    bit  sel_h     [8192];
    bit  bin_h     [8192];

    typedef struct packed {
        logic [11:0] p0;
        logic [11:0] p1;
        logic        split;
        logic        sel;
        logic        bin;
        logic [11:0] exp_l;
        logic [11:0] exp_r;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", name, n, got, exp);
        end
    endtask

    function automatic bit in_win(input int c);
        int h = c % H_TOT;
        int v = (c / H_TOT) % V_TOT;
        return (h >= H0) && (h < H0 + IMG_W) && (v >= V0) && (v < V0 + IMG_H);
    endfunction

    function automatic int pix_idx(input int c);
        return ((c / H_TOT) % V_TOT - V0) * IMG_W + (c % H_TOT - H0);
    endfunction

    function automatic logic [11:0] model_rgb(input int c);
        int m, col, luma;
        bit sel;
        logic [11:0] d;
        m = c - LAT - 1;
        if (!in_win(m)) return 12'h000;
        col = m % H_TOT - H0;
        sel = split_h[m] ? (col >= IMG_W / 2) : sel_h[m];
        d   = sel ? mem1[pix_idx(m)] : mem0[pix_idx(m)];
        if (!bin_h[c-1]) return d;
        luma = int'(d[11:8]) * 30 + int'(d[7:4]) * 59 + int'(d[3:0]) * 11;
        return (luma > th_m) ? 12'hFFF : 12'h000;
    endfunction

    task automatic check_cycle();
        int h, v, m;
        h = n % H_TOT;
        v = (n / H_TOT) % V_TOT;
        check("frame_start", 32'(frame_start), 32'(n > 0 && h == 0 && v == 0));
        if (in_win(n)) begin
            check("rd_addr", 32'(rd_addr), 32'(pix_idx(n)));
            last_win_addr = int'(rd_addr);
        end
        if (h == 1 && v == 0) check("rd_addr_origin", 32'(rd_addr), 32'd0);
        if (n >= LAT + 1) begin
            m = n - LAT - 1;
            check("hs", 32'(hs), 32'((m % H_TOT) >= H_SYNC));
            check("vs", 32'(vs), 32'(((m / H_TOT) % V_TOT) >= V_SYNC));
            check("rgb", 32'({red, green, blue}), 32'(model_rgb(n)));
            if (in_win(m) && pix_idx(m) == 0)        cap_l = {red, green, blue};
            if (in_win(m) && pix_idx(m) == NPIX - 1) cap_r = {red, green, blue};
        end else begin
            check("hs_idle", 32'(hs), 32'd1);
            check("vs_idle", 32'(vs), 32'd1);
            check("rgb_idle", 32'({red, green, blue}), 32'd0);
        end
    endtask

    // Drives the inputs for clock n and records them for the model.
    task automatic apply_inputs();
        int a;
        split_en = split_req;
        ch_sel   = sel_req;
        bin_mode = bin_req;
        split_h[n] = split_req;
        sel_h[n]   = sel_req;
        bin_h[n]   = bin_req;
        a = (n >= LAT) ? addr_hist[n - LAT] : 0;
        ch0_data = mem0[a & 127];
        ch1_data = mem1[a & 127];
    endtask

    task automatic tick();
        @(posedge clk_25m);
        #1;
        n++;
        check_cycle();
        addr_hist[n] = int'(rd_addr);
        if (rand_on) begin
            split_req = 1'($urandom_range(0, 1));
            sel_req   = 1'($urandom_range(0, 1));
            bin_req   = 1'($urandom_range(0, 1));
        end
        apply_inputs();
    endtask

    task automatic release_reset();
        @(negedge clk_25m);
        rst_n = 1'b1;
        n = 0;
        addr_hist[0] = 0;
        apply_inputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
        check({tag, "_hs"}, 32'(hs), 32'd1);
        check({tag, "_vs"}, 32'(vs), 32'd1);
        check({tag, "_threshold"}, 32'(threshold), 32'd650);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    task automatic pulse(input bit up, input bit dn);
        adj_up = up;
        adj_down = dn;
        repeat (3) tick();
        adj_up = 1'b0;
        adj_down = 1'b0;
        repeat (5) tick();
        if (up && !dn && th_m + 20 <= 1000) th_m += 20;
        if (dn && !up && th_m - 20 >= 200)  th_m -= 20;
        check("threshold", 32'(threshold), 32'(th_m));
    endtask

    task automatic to_frame_boundary();
        while ((n % FRAME) != 0) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        adj_up = 1'b0;
        adj_down = 1'b0;
        split_en = 1'b0; ch_sel = 1'b0; bin_mode = 1'b0;
        ch0_data = '0; ch1_data = '0;
        for (int i = 0; i < 128; i++) begin
            mem0[i] = 12'($urandom);
            mem1[i] = 12'($urandom);
        end
        vecs[0] = '{p0: 12'hF00, p1: 12'h00F, split: 1, sel: 0, bin: 0, exp_l: 12'hF00, exp_r: 12'h00F};
        vecs[1] = '{p0: 12'h555, p1: 12'hAAA, split: 0, sel: 0, bin: 1, exp_l: 12'h000, exp_r: 12'h000};
        vecs[2] = '{p0: 12'h777, p1: 12'h000, split: 0, sel: 0, bin: 1, exp_l: 12'hFFF, exp_r: 12'hFFF};
        vecs[3] = '{p0: 12'hB3D, p1: 12'h000, split: 0, sel: 0, bin: 1, exp_l: 12'h000, exp_r: 12'h000};
        vecs[4] = '{p0: 12'h123, p1: 12'hABC, split: 0, sel: 1, bin: 0, exp_l: 12'hABC, exp_r: 12'hABC};
        vecs[5] = '{p0: 12'h0F0, p1: 12'h000, split: 1, sel: 1, bin: 1, exp_l: 12'hFFF, exp_r: 12'h000};

        repeat (3) @(posedge clk_25m);
        #1;
        check_reset_values("reset");
        release_reset();

        // One full frame with random memory contents, colour, camera 0.
        last_win_addr = -1;
        repeat (FRAME + 10) tick();
        check("rd_addr_last", 32'(last_win_addr), 32'(NPIX - 1));

        // Constant-colour frames from the vector table.
        for (int i = 0; i < 6; i++) begin
            to_frame_boundary();
            for (int k = 0; k < 128; k++) begin
                mem0[k] = vecs[i].p0;
                mem1[k] = vecs[i].p1;
            end
            split_req = vecs[i].split;
            sel_req   = vecs[i].sel;
            bin_req   = vecs[i].bin;
            cap_l = 12'h999;
            cap_r = 12'h999;
            repeat (FRAME) tick();
            check("vec_left", 32'(cap_l), 32'(vecs[i].exp_l));
            check("vec_right", 32'(cap_r), 32'(vecs[i].exp_r));
        end

        // Threshold stepping; colour mode keeps pixels independent of it.
        bin_req = 1'b0;
        repeat (5) tick();
        adj_up = 1'b1;
        repeat (20) tick();
        adj_up = 1'b0;
        repeat (6) tick();
        th_m += 20;
        check("th_held", 32'(threshold), 32'(th_m));
        for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        for (int i = 0; i < 45; i++) pulse(1'b0, 1'b1);
        check("th_floor", 32'(threshold), 32'd210);

        // Random memory and per-clock random modes against the model.
        to_frame_boundary();
        for (int k = 0; k < 128; k++) begin
            mem0[k] = 12'($urandom);
            mem1[k] = 12'($urandom);
        end
        rand_on = 1;
        repeat (4 * FRAME) tick();
        rand_on = 0;

        // Reset in the middle of an active line.
        for (int k = 0; k < FRAME && !((n % H_TOT) == 10 && ((n / H_TOT) % V_TOT) == 6); k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) @(posedge clk_25m);
        th_m = 650;
        split_req = 1'b1;
        bin_req = 1'b1;
        release_reset();
        last_win_addr = -1;
        repeat (FRAME + 10) tick();
        check("rd_addr_last_after_reset", 32'(last_win_addr), 32'(NPIX - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
